// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide handshake: op request from EX, stall/done and architectural HI/LO back.
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             annul_i;
  logic             stall_from_muldiv;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  stall_from_muldiv, done_o, hi_o, lo_o
  );
  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output stall_from_muldiv, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers; divide is restoring, one bit per cycle.
module ex_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);
  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             isdiv_q, isdiv_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dvs_q, dvs_d, rem_q, rem_d, quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             is_mul, is_div, op_sgn;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]   shifted, diff;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  assign is_mul = bus.op_i == OP_MULT || bus.op_i == OP_MULTU;
  assign is_div = bus.op_i == OP_DIV  || bus.op_i == OP_DIVU;
  assign op_sgn = ~bus.op_i[0];
  assign a_abs  = (op_sgn && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
  assign b_abs  = (op_sgn && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

  // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  // Sign-extend to 2W so one multiplier serves both signed and unsigned products.
  assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // MIN / -1 falls out naturally: |MIN| / 1 = MIN, and negating MIN is MIN.
  assign q_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
  assign r_fix = (sgn_q && a_q[WIDTH-1]) ? -rem_q : rem_q;

  assign bus.stall_from_muldiv = rst && !bus.annul_i &&
    ((state_q == S_IDLE && bus.start_i && (is_mul || is_div)) ||
     state_q == S_MUL || state_q == S_DIV);
  assign bus.done_o = rst && state_q == S_FIN;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    isdiv_d = isdiv_q;
    a_d     = a_q;
    b_d     = b_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: if (bus.start_i && !bus.annul_i) begin
        if (is_mul || is_div) begin
          sgn_d   = op_sgn;
          isdiv_d = is_div;
          a_d     = bus.opdata1_i;
          b_d     = bus.opdata2_i;
          dvs_d   = b_abs;
          quo_d   = a_abs;
          rem_d   = '0;
          state_d = is_mul ? S_MUL : S_DIV;
          cnt_d   = is_mul ? CW'(MUL_LAT - 1) : CW'(WIDTH - 1);
        end else if (bus.op_i == OP_MTHI) begin
          hi_d = bus.opdata1_i;
        end else if (bus.op_i == OP_MTLO) begin
          lo_d = bus.opdata1_i;
        end
      end
      S_MUL: begin
        if (bus.annul_i)      state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_FIN;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      S_DIV: begin
        if (bus.annul_i) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = S_FIN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        // Committed op: annul_i cannot stop this write.
        state_d = S_IDLE;
        if (!isdiv_q) begin
          {hi_d, lo_d} = prod;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = q_fix;
          hi_d = r_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      isdiv_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      isdiv_q <= isdiv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
